// File: rtl/indexed_rsh_pkg.sv
// Shared opcode definitions for the indexed right-shift insertion array.
package indexed_rsh_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_INSERT = 2'd0,
    OP_DELETE = 2'd1,
    OP_POP    = 2'd2,
    OP_CLEAR  = 2'd3
  } rsh_op_e;

endpackage

// File: rtl/indexed_rsh_cell.sv
// One slot of the insertion array: holds, shifts right, loads the insert
// word, shifts left or clears depending on opcode and its position vs p.
module indexed_rsh_cell
  import indexed_rsh_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int SLOT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [OP_W-1:0]   i_op,
  input  logic [IDX_W-1:0]  i_p,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_q
);

  localparam logic [IDX_W-1:0] SLOT_IDX = IDX_W'(SLOT);

  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] w_nxt;
  rsh_op_e           w_op;

  assign w_op = rsh_op_e'(i_op);
  assign o_q  = r_q;

  // Select the next slot value from its neighbours, the insert word or zero.
  always_comb begin
    w_nxt = r_q;
    if (i_en) begin
      case (w_op)
        OP_INSERT: begin
          if (SLOT_IDX > i_p)       w_nxt = i_left;
          else if (SLOT_IDX == i_p) w_nxt = i_data;
        end
        OP_DELETE, OP_POP: begin
          if (SLOT_IDX >= i_p) w_nxt = i_right;
        end
        OP_CLEAR: w_nxt = '0;
        default:  w_nxt = r_q;
      endcase
    end
  end

  // Slot register; empty slots always read as zero, including after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= w_nxt;
  end

endmodule

// File: rtl/indexed_rsh_array.sv
// Ordered insertion array with indexed insert/delete, head pop and clear.
// Optional build macro INDEXED_RSH_SORTED_INS_EN: INSERT ignores cmd_idx and
// places the word after all entries that are <= it (stable ascending order).
module indexed_rsh_array
  import indexed_rsh_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic [IDX_W-1:0]        cmd_idx,
  input  logic [DATA_W-1:0]       cmd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [DEPTH*DATA_W-1:0] arr_data,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty,
  output logic                    err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  r_count;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_err;

  logic [DATA_W-1:0] w_slot [DEPTH];
  rsh_op_e           w_op;
  logic              w_acc;
  logic              w_legal;
  logic              w_do;
  logic [CNT_W-1:0]  w_idx_ext;
  logic [IDX_W-1:0]  w_ins_p;
  logic [IDX_W-1:0]  w_p;

  assign w_op      = rsh_op_e'(cmd_op);
  assign cmd_ready = !r_out_valid || out_ready;
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_do      = w_acc && w_legal;
  assign w_idx_ext = CNT_W'(cmd_idx);

  assign count     = r_count;
  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == '0);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err       = r_err;

`ifdef INDEXED_RSH_SORTED_INS_EN
  logic [DEPTH-1:0] w_gt;

  // Insert position is the first occupied slot strictly greater than the word.
  always_comb begin
    w_ins_p = r_count[IDX_W-1:0];
    for (int i = 0; i < DEPTH; i++)
      w_gt[i] = (CNT_W'(i) < r_count) && (w_slot[i] > cmd_data);
    for (int i = DEPTH-1; i >= 0; i--)
      if (w_gt[i]) w_ins_p = IDX_W'(i);
  end
`else
  // Insert position is the requested index clamped to the end of the list.
  always_comb begin
    w_ins_p = cmd_idx;
    if (w_idx_ext >= r_count) w_ins_p = r_count[IDX_W-1:0];
  end
`endif

  // Shift pivot and legality of the presented command.
  always_comb begin
    w_p     = '0;
    w_legal = 1'b1;
    case (w_op)
      OP_INSERT: begin
        w_p     = w_ins_p;
        w_legal = (r_count != DEPTH_C);
      end
      OP_DELETE: begin
        w_p     = cmd_idx;
        w_legal = (w_idx_ext < r_count);
      end
      OP_POP:   w_legal = (r_count != '0);
      default:  w_legal = 1'b1;
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [DATA_W-1:0] w_left;
    logic [DATA_W-1:0] w_right;
    if (g == 0) begin : g_first
      assign w_left = '0;
    end else begin : g_mid_l
      assign w_left = w_slot[g-1];
    end
    if (g == DEPTH-1) begin : g_last
      assign w_right = '0;
    end else begin : g_mid_r
      assign w_right = w_slot[g+1];
    end

    indexed_rsh_cell #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .SLOT   (g)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_do),
      .i_op    (cmd_op),
      .i_p     (w_p),
      .i_left  (w_left),
      .i_right (w_right),
      .i_data  (cmd_data),
      .o_q     (w_slot[g])
    );

    assign arr_data[g*DATA_W +: DATA_W] = w_slot[g];
  end

  // Occupancy tracks every legal accepted command; err flags illegal ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_acc && !w_legal;
      if (w_do) begin
        case (w_op)
          OP_INSERT:         r_count <= r_count + 1'b1;
          OP_DELETE, OP_POP: r_count <= r_count - 1'b1;
          default:           r_count <= '0;
        endcase
      end
    end
  end

  // Output register: a POP reloads it, otherwise it drains on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_do && (w_op == OP_POP)) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_slot[0];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_indexed_rsh_array.sv
// Directed self-checking bench for indexed_rsh_array (DEPTH=8, DATA_W=32).
module tb_indexed_rsh_array;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [2:0]        cmd_idx;
  logic [31:0]       cmd_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [255:0]      arr_data;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic              err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] e [DEPTH];

  localparam logic [1:0] INS = 2'd0, DEL = 2'd1, POP = 2'd2, CLR = 2'd3;

  indexed_rsh_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_idx   (cmd_idx),
    .cmd_data  (cmd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .arr_data  (arr_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pk();
    logic [255:0] v;
    for (int i = 0; i < DEPTH; i++) v[i*32 +: 32] = e[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [2:0] idx, input logic [31:0] d);
    @(negedge clk);
    cmd_op = op; cmd_idx = idx; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_arr"}, arr_data, '0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_od"}, out_data, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = INS; cmd_idx = '0;
    cmd_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    chk("reset_rdy", cmd_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    // Indexed inserts: 100@0, 300@1, 200@1 -> [100,200,300]
    cmd(INS, 0, 100); chk("ins0_err", err, 0);
    cmd(INS, 1, 300); chk("ins1_err", err, 0);
    cmd(INS, 1, 200); chk("ins2_err", err, 0);
    e = '{100, 200, 300, 0, 0, 0, 0, 0};
    chk("ins_arr", arr_data, pk());
    chk("ins_count", count, 3);
    chk("ins_empty", empty, 0);

    // Delete idx 0, then out-of-range delete
    cmd(DEL, 0, 0);
    e = '{200, 300, 0, 0, 0, 0, 0, 0};
    chk("del0_arr", arr_data, pk());
    chk("del0_count", count, 2);
    chk("del0_err", err, 0);
    cmd(DEL, 5, 0);
    chk("del5_arr", arr_data, pk());
    chk("del5_count", count, 2);
    chk("del5_err", err, 1);
    idle();
    chk("del5_err_drop", err, 0);

    // Clamped index: idx 7 with count 2 appends at slot 2
    cmd(INS, 7, 55);
    e = '{200, 300, 55, 0, 0, 0, 0, 0};
    chk("clamp_arr", arr_data, pk());
    chk("clamp_err", err, 0);

    // Back-to-back pops with out_ready held high
    cmd(CLR, 0, 0);
    chk("clr_arr", arr_data, '0);
    chk("clr_count", count, 0);
    cmd(INS, 0, 100); cmd(INS, 1, 200); cmd(INS, 2, 300);
    out_ready = 1'b1;
    @(negedge clk); cmd_op = POP; cmd_valid = 1'b1;
    @(posedge clk); #1;
    chk("pop1_data", out_data, 100); chk("pop1_ov", out_valid, 1); chk("pop1_rdy", cmd_ready, 1);
    @(posedge clk); #1;
    chk("pop2_data", out_data, 200); chk("pop2_ov", out_valid, 1); chk("pop2_rdy", cmd_ready, 1);
    @(posedge clk); #1;
    chk("pop3_data", out_data, 300); chk("pop3_ov", out_valid, 1);
    cmd_valid = 1'b0;
    chk("pop3_count", count, 0);
    chk("pop3_empty", empty, 1);
    idle();
    chk("pop_drain_ov", out_valid, 0);

    // Backpressure: out_ready low stalls further commands
    cmd(INS, 0, 5); cmd(INS, 1, 6);
    out_ready = 1'b0;
    cmd(POP, 0, 0);
    chk("bp_data", out_data, 5);
    chk("bp_ov", out_valid, 1);
    chk("bp_rdy", cmd_ready, 0);
    cmd(POP, 0, 0);
    chk("bp_stall_count", count, 1);
    chk("bp_stall_data", out_data, 5);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_rdy_back", cmd_ready, 1);
    cmd(POP, 0, 0);
    chk("bp_pop2_data", out_data, 6);
    chk("bp_pop2_count", count, 0);

    // Fill to full, then insert into a full array
    cmd(CLR, 0, 0);
    for (int k = 0; k < DEPTH; k++) cmd(INS, 3'(k), 32'(k + 1));
    e = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk("fill_arr", arr_data, pk());
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    cmd(INS, 3, 99);
    chk("full_arr", arr_data, pk());
    chk("full_count", count, 8);
    chk("full_err", err, 1);
    idle();
    chk("full_err_drop", err, 0);

`ifdef INDEXED_RSH_SORTED_INS_EN
    // Sorted insert with arbitrary indices
    cmd(CLR, 0, 0);
    cmd(INS, 3'($urandom_range(7)), 50);
    cmd(INS, 3'($urandom_range(7)), 10);
    cmd(INS, 3'($urandom_range(7)), 30);
    cmd(INS, 3'($urandom_range(7)), 30);
    cmd(INS, 3'($urandom_range(7)), 70);
    e = '{10, 30, 30, 50, 70, 0, 0, 0};
    chk("sort_arr", arr_data, pk());
    chk("sort_count", count, 5);
`endif

    // Reset mid-insert while output is pending
    cmd(CLR, 0, 0);
    cmd(INS, 0, 42);
    out_ready = 1'b0;
    cmd(POP, 0, 0);
    chk("pre_rst_ov", out_valid, 1);
    chk("pre_rst_od", out_data, 42);
    cmd(INS, 0, 7);
    @(negedge clk);
    out_ready = 1'b1; cmd_op = INS; cmd_idx = 0; cmd_data = 77; cmd_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk); cmd_valid = 1'b0; rst_n = 1'b1;
    idle();
    chk("post_rst_count", count, 0);

    // Pop on empty
    cmd(POP, 0, 0);
    chk("pop_empty_err", err, 1);
    chk("pop_empty_ov", out_valid, 0);
    chk("pop_empty_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
